// File: rtl/pulse_rate_meter_pkg.sv
// Shared types and constants for the pulse rate meter: FSM state encoding and
// the gate window length helper.
package pulse_rate_meter_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Window length in clk cycles for a given clock rate and gate rate.
   function automatic int gate_max(input int clk_hz, input int gate_hz);
      return clk_hz / gate_hz;
   endfunction

endpackage

// File: rtl/pulse_rate_meter_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous strobe followed by a registered
// rising-edge detector; rise_o is a one-cycle pulse per synchronised rise.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic rise_q;

   // rise_q is registered so downstream logic sees a clean, glitch-free strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         rise_q  <= sync1_q & ~sync2_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts rising edges of an asynchronous pulse line per locally generated gate
// window and delivers each result over valid/ready. Optional macro
// PULSE_RATE_METER_PERIOD_EN adds meas_period (spacing of the last two edges).
module pulse_rate_meter
   import pulse_rate_meter_pkg::*;
#(
   parameter int CLK_SPEED_HZ = 100_000_000,
   parameter int GATE_HZ      = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] meas_count,
   output logic             meas_sat,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             window_tick
`ifdef PULSE_RATE_METER_PERIOD_EN
   ,
   output logic [CNT_W-1:0] meas_period
`endif
);

   localparam int GATE_MAX = gate_max(CLK_SPEED_HZ, GATE_HZ);
   localparam int GATE_W   = $clog2(GATE_MAX);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_MAX - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_e state_q, state_d;
   logic running;
   logic windowEnd;
   logic edgeStrobe;

   logic [GATE_W-1:0] gateCnt_q, gateCnt_d;
   logic [CNT_W-1:0]  edgeCnt_q, edgeCnt_d;
   logic              winSat_q, winSat_d;
   logic [CNT_W-1:0]  closeCount;
   logic              closeSat;
   logic              edgeAtMax;

   logic [CNT_W-1:0]  measCount_q, measCount_d;
   logic              measSat_q, measSat_d;
   logic              measValid_q, measValid_d;
   logic              overrun_q, overrun_d;
   logic              xfer;

   sync_edge_detect u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (pulse_in),
      .rise_o  (edgeStrobe)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en)  state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      running   = (state_q == RUN);
      windowEnd = running && (gateCnt_q == GATE_LAST);
   end

   assign window_tick = windowEnd;

   // Sat means at least one edge was dropped because the counter was pinned at max.
   always_comb begin
      edgeAtMax  = (edgeCnt_q == CNT_MAX);
      closeCount = (edgeStrobe && !edgeAtMax) ? edgeCnt_q + CNT_W'(1) : edgeCnt_q;
      closeSat   = winSat_q | (edgeStrobe & edgeAtMax);
      gateCnt_d  = gateCnt_q;
      edgeCnt_d  = edgeCnt_q;
      winSat_d   = winSat_q;
      if (!running || windowEnd) begin
         gateCnt_d = '0;
         edgeCnt_d = '0;
         winSat_d  = 1'b0;
      end else begin
         gateCnt_d = gateCnt_q + GATE_W'(1);
         edgeCnt_d = closeCount;
         winSat_d  = closeSat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gateCnt_q <= '0;
         edgeCnt_q <= '0;
         winSat_q  <= 1'b0;
      end else begin
         gateCnt_q <= gateCnt_d;
         edgeCnt_q <= edgeCnt_d;
         winSat_q  <= winSat_d;
      end
   end

   always_comb begin
      xfer        = measValid_q & meas_ready;
      measCount_d = measCount_q;
      measSat_d   = measSat_q;
      measValid_d = measValid_q;
      overrun_d   = overrun_q;
      if (windowEnd) begin
         measCount_d = closeCount;
         measSat_d   = closeSat;
         measValid_d = 1'b1;
      end else if (xfer) begin
         measValid_d = 1'b0;
      end
      if (xfer)                          overrun_d = 1'b0;
      else if (windowEnd && measValid_q) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         measCount_q <= '0;
         measSat_q   <= 1'b0;
         measValid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         measCount_q <= measCount_d;
         measSat_q   <= measSat_d;
         measValid_q <= measValid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign meas_count = measCount_q;
   assign meas_sat   = measSat_q;
   assign meas_valid = measValid_q;
   assign overrun    = overrun_q;

`ifdef PULSE_RATE_METER_PERIOD_EN
   logic [CNT_W-1:0] since_q, since_d;
   logic [CNT_W-1:0] lastPeriod_q, lastPeriod_d;
   logic [CNT_W-1:0] measPeriod_q, measPeriod_d;
   logic [CNT_W-1:0] closePeriod;

   // since_q holds cycles elapsed since the latest edge; it only yields a period
   // when an earlier edge of the same window exists.
   always_comb begin
      closePeriod  = (edgeStrobe && (edgeCnt_q != '0)) ? since_q : lastPeriod_q;
      since_d      = since_q;
      lastPeriod_d = closePeriod;
      measPeriod_d = windowEnd ? closePeriod : measPeriod_q;
      if (!running) begin
         since_d      = '0;
         lastPeriod_d = '0;
      end else begin
         if (edgeStrobe)             since_d = CNT_W'(1);
         else if (since_q != CNT_MAX) since_d = since_q + CNT_W'(1);
         if (windowEnd) lastPeriod_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         since_q      <= '0;
         lastPeriod_q <= '0;
         measPeriod_q <= '0;
      end else begin
         since_q      <= since_d;
         lastPeriod_q <= lastPeriod_d;
         measPeriod_q <= measPeriod_d;
      end
   end

   assign meas_period = measPeriod_q;
`endif

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Self-checking bench for pulse_rate_meter: table-driven pulse trains, directed
// handshake/enable/reset sequences and randomized traffic against a window model.
module tb_pulse_rate_meter;

   localparam int CLK_HZ   = 1000;
   localparam int GATE_HZ  = 10;
   localparam int GATE_MAX = 100;
   localparam int CNT_W    = 16;
   localparam int SAT_W    = 4;
   localparam int MAX_MAIN = 65535;
   localparam int MAX_SAT  = 15;

   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b0, pulseIn = 1'b0, measReady = 1'b0;
   logic [CNT_W-1:0] measCount;
   logic measSat, measValid, overrun, windowTick;
   logic [SAT_W-1:0] measCount4;
   logic measSat4, measValid4, overrun4, windowTick4;
`ifdef PULSE_RATE_METER_PERIOD_EN
   logic [CNT_W-1:0] measPeriod;
   logic [SAT_W-1:0] measPeriod4;
`endif

   always #5 clk = ~clk;

   pulse_rate_meter #(.CLK_SPEED_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .pulse_in(pulseIn),
      .meas_count(measCount), .meas_sat(measSat), .meas_valid(measValid),
      .meas_ready(measReady), .overrun(overrun), .window_tick(windowTick)
`ifdef PULSE_RATE_METER_PERIOD_EN
      , .meas_period(measPeriod)
`endif
   );

   pulse_rate_meter #(.CLK_SPEED_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(SAT_W)) dutSat (
      .clk(clk), .rst(rst), .en(en), .pulse_in(pulseIn),
      .meas_count(measCount4), .meas_sat(measSat4), .meas_valid(measValid4),
      .meas_ready(measReady), .overrun(overrun4), .window_tick(windowTick4)
`ifdef PULSE_RATE_METER_PERIOD_EN
      , .meas_period(measPeriod4)
`endif
   );

   int compared = 0;
   int mismatched = 0;

   // Reference model: cycle index, run interval and the cycles at which each
   // detected edge lands (input rise cycle + 2).
   int cyc = 0;
   bit mRun = 0;
   int runStart = 0;
   bit prevLevel = 0;
   int strobeQ[$];
   bit eValid = 0, eSat = 0, eSat4 = 0, eOverrun = 0;
   int eCount = 0, eCount4 = 0, ePeriod = 0, ePeriod4 = 0;

   typedef struct {
      int period;
      int expCount;
      bit expSat;
      int expCount4;
      bit expSat4;
      int expPeriod;
      int expPeriod4;
   } vec_t;

   function automatic int minI(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit e, input bit p, input bit rd);
      rst       = r;
      en        = e;
      measReady = rd;
      if (p && !prevLevel) strobeQ.push_back(cyc + 2);
      prevLevel = p;
      pulseIn   = p;
   endtask

   task automatic closeWindow(input int w);
      int n, last, prev;
      n = 0; last = -1; prev = -1;
      foreach (strobeQ[k]) begin
         if (strobeQ[k] >= w - (GATE_MAX - 1) && strobeQ[k] <= w) begin
            n++;
            prev = last;
            last = strobeQ[k];
         end
      end
      eCount   = minI(n, MAX_MAIN);
      eSat     = (n > MAX_MAIN);
      eCount4  = minI(n, MAX_SAT);
      eSat4    = (n > MAX_SAT);
      ePeriod  = (n >= 2) ? (last - prev) : 0;
      ePeriod4 = minI(ePeriod, MAX_SAT);
      while (strobeQ.size() > 0 && strobeQ[0] < w - GATE_MAX) void'(strobeQ.pop_front());
   endtask

   task automatic modelEdge();
      bit xfer;
      if (rst) begin
         mRun = 0; eValid = 0; eSat = 0; eSat4 = 0; eOverrun = 0;
         eCount = 0; eCount4 = 0; ePeriod = 0; ePeriod4 = 0;
         strobeQ.delete();
         prevLevel = 0;
      end else begin
         xfer = eValid && measReady;
         if (mRun && ((cyc - 1 - runStart) % GATE_MAX == GATE_MAX - 1)) begin
            closeWindow(cyc - 1);
            if (xfer)        eOverrun = 0;
            else if (eValid) eOverrun = 1;
            eValid = 1;
         end else if (xfer) begin
            eValid = 0;
            eOverrun = 0;
         end
         if (!mRun && en) begin
            mRun = 1;
            runStart = cyc;
         end else if (mRun && !en) begin
            mRun = 0;
         end
      end
   endtask

   task automatic stepCycle();
      bit expTick;
      @(posedge clk);
      #1;
      cyc++;
      modelEdge();
      expTick = mRun && ((cyc - runStart) % GATE_MAX == GATE_MAX - 1);
      checkOutput("window_tick", longint'(windowTick), longint'(expTick));
      checkOutput("meas_valid", longint'(measValid), longint'(eValid));
      checkOutput("overrun", longint'(overrun), longint'(eOverrun));
      checkOutput("meas_count", longint'(measCount), longint'(eCount));
      checkOutput("meas_sat", longint'(measSat), longint'(eSat));
      checkOutput("w4.window_tick", longint'(windowTick4), longint'(expTick));
      checkOutput("w4.meas_valid", longint'(measValid4), longint'(eValid));
      checkOutput("w4.overrun", longint'(overrun4), longint'(eOverrun));
      checkOutput("w4.meas_count", longint'(measCount4), longint'(eCount4));
      checkOutput("w4.meas_sat", longint'(measSat4), longint'(eSat4));
`ifdef PULSE_RATE_METER_PERIOD_EN
      checkOutput("meas_period", longint'(measPeriod), longint'(ePeriod));
      checkOutput("w4.meas_period", longint'(measPeriod4), longint'(ePeriod4));
`endif
   endtask

   task automatic resetDut();
      applyStimulus(1, 0, 0, 0);
      stepCycle();
      stepCycle();
      applyStimulus(0, 0, 0, 0);
      stepCycle();
   endtask

   function automatic bit pulseAt(input int i, input int period);
      if (period <= 0) return 0;
      return (i % period) < (period / 2);
   endfunction

   initial begin
      vec_t vecs[6];
      int validCycles, earlyValid, anyValid;
      bit p, enR, pR, rdR, rR, holdReady;

      vecs[0] = '{10, 10, 0, 10, 0, 10, 10};
      vecs[1] = '{ 0,  0, 0,  0, 0,  0,  0};
      vecs[2] = '{20,  5, 0,  5, 0, 20, 15};
      vecs[3] = '{25,  4, 0,  4, 0, 25, 15};
      vecs[4] = '{ 4, 25, 0, 15, 1,  4,  4};
      vecs[5] = '{ 2, 50, 0, 15, 1,  2,  2};

      $display("[TB] reset state");
      resetDut();
      checkOutput("rst.meas_valid", longint'(measValid), 0);
      checkOutput("rst.meas_count", longint'(measCount), 0);
      checkOutput("rst.overrun", longint'(overrun), 0);
      checkOutput("rst.window_tick", longint'(windowTick), 0);

      $display("[TB] table-driven pulse trains");
      for (int v = 0; v < 6; v++) begin
         resetDut();
         validCycles = 0;
         for (int i = 0; i < 306; i++) begin
            applyStimulus(0, 1, pulseAt(i, vecs[v].period), 1);
            stepCycle();
            if (measValid) begin
               validCycles++;
               if (validCycles >= 2) begin
                  checkOutput("tbl.count", longint'(measCount), longint'(vecs[v].expCount));
                  checkOutput("tbl.sat", longint'(measSat), longint'(vecs[v].expSat));
                  checkOutput("tbl.count4", longint'(measCount4), longint'(vecs[v].expCount4));
                  checkOutput("tbl.sat4", longint'(measSat4), longint'(vecs[v].expSat4));
`ifdef PULSE_RATE_METER_PERIOD_EN
                  checkOutput("tbl.period", longint'(measPeriod), longint'(vecs[v].expPeriod));
                  checkOutput("tbl.period4", longint'(measPeriod4), longint'(vecs[v].expPeriod4));
`endif
               end
            end
         end
         checkOutput("tbl.validCycles", longint'(validCycles), 3);
      end

      $display("[TB] overrun with consumer stalled");
      resetDut();
      for (int i = 0; i < 250; i++) begin
         applyStimulus(0, 1, pulseAt(i, 20), 0);
         stepCycle();
      end
      checkOutput("ovr.overrun", longint'(overrun), 1);
      checkOutput("ovr.valid", longint'(measValid), 1);
      checkOutput("ovr.count", longint'(measCount), 5);
      applyStimulus(0, 1, pulseAt(250, 20), 1);
      stepCycle();
      checkOutput("ovr.clearOverrun", longint'(overrun), 0);
      checkOutput("ovr.validDrop", longint'(measValid), 0);

      $display("[TB] enable dropped mid-window");
      resetDut();
      anyValid = 0;
      for (int i = 0; i < 41; i++) begin
         applyStimulus(0, 1, pulseAt(i, 10), 1);
         stepCycle();
         if (measValid) anyValid++;
      end
      for (int i = 41; i < 161; i++) begin
         applyStimulus(0, 0, pulseAt(i, 10), 1);
         stepCycle();
         if (measValid) anyValid++;
      end
      checkOutput("en.noPartialResult", longint'(anyValid), 0);
      applyStimulus(0, 1, pulseAt(161, 10), 1);
      stepCycle();
      earlyValid = 0;
      for (int k = 1; k < 100; k++) begin
         applyStimulus(0, 1, pulseAt(161 + k, 10), 1);
         stepCycle();
         if (measValid) earlyValid++;
      end
      checkOutput("en.noEarlyValid", longint'(earlyValid), 0);
      checkOutput("en.tickAt99", longint'(windowTick), 1);
      applyStimulus(0, 1, pulseAt(261, 10), 1);
      stepCycle();
      checkOutput("en.validAt100", longint'(measValid), 1);
      checkOutput("en.count", longint'(measCount), 10);

      $display("[TB] reset while a result is pending");
      resetDut();
      for (int i = 0; i < 105; i++) begin
         applyStimulus(0, 1, pulseAt(i, 10), 0);
         stepCycle();
      end
      checkOutput("rstp.pendingValid", longint'(measValid), 1);
      checkOutput("rstp.pendingCount", longint'(measCount), 10);
      applyStimulus(1, 1, pulseAt(105, 10), 0);
      stepCycle();
      checkOutput("rstp.valid", longint'(measValid), 0);
      checkOutput("rstp.count", longint'(measCount), 0);
      checkOutput("rstp.sat", longint'(measSat), 0);
      checkOutput("rstp.overrun", longint'(overrun), 0);
      checkOutput("rstp.tick", longint'(windowTick), 0);

      $display("[TB] pulse every 7 clk");
      resetDut();
      for (int i = 0; i < 210; i++) begin
         applyStimulus(0, 1, pulseAt(i, 7), 1);
         stepCycle();
         if (measValid) begin
            checkOutput("p7.count14or15", longint'(measCount == 14 || measCount == 15), 1);
`ifdef PULSE_RATE_METER_PERIOD_EN
            checkOutput("p7.period", longint'(measPeriod), 7);
`endif
         end
      end

      $display("[TB] randomized traffic");
      resetDut();
      enR = 1; pR = 0; holdReady = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 249) == 0) enR = !enR;
         if ($urandom_range(0, 149) == 0) holdReady = !holdReady;
         rdR = !holdReady && ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) pR = !pR;
         rR = ($urandom_range(0, 1499) == 0);
         applyStimulus(rR, enR, pR, rdR);
         stepCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
